// File: rtl/ieee32_pkg.sv
// Shared binary32 field widths, special-value constants and the subtractor
// FSM state type.
package ieee32_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned EXT_W  = 27;  // hidden bit + 23 fraction + guard/round/sticky
  localparam int unsigned SUM_W  = 28;  // EXT_W plus carry-out

  localparam logic [WORD_W-1:0] NAN_VAL  = 32'hFFFF_FFFF;
  localparam logic [EXP_W-1:0]  EXP_ONES = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/lzc28.sv
// Combinational leading-zero counter for the 28-bit sum; an all-zero input
// returns 28.
module lzc28 (
  input  logic [27:0] din,
  output logic [4:0]  count
);

  always_comb begin
    count = 5'd28;
    // Ascending scan: the highest set bit is the last to overwrite.
    for (int unsigned i = 0; i < 28; i++) begin
      if (din[i]) count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/ieee32float_subtractor.sv
// Multi-cycle binary32 subtractor (s = a - b): align, add, normalise and
// round-to-nearest-even, with a valid/ready handshake on both sides.
module ieee32float_subtractor
  import ieee32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] s
);

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [WORD_W-1:0]   s_q, s_d;
  logic [WORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic                sign_q, sign_d;
  logic signed [9:0]   exp_q, exp_d;
  logic [EXT_W-1:0]    mag_l_q, mag_l_d, mag_s_q, mag_s_d;
  logic                sub_q, sub_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [EXT_W-1:0]    nm_q, nm_d;
  logic                zero_q, zero_d;

  // Special-operand detection on the raw inputs, with b already negated
  logic [WORD_W-1:0] bn;
  logic              a_inf, a_nan, b_inf, b_nan, special_in;
  logic [WORD_W-1:0] special_res;

  always_comb begin
    bn          = {~b[31], b[30:0]};
    a_inf       = (a[30:23] == EXP_ONES) && (a[22:0] == '0);
    a_nan       = (a[30:23] == EXP_ONES) && (a[22:0] != '0);
    b_inf       = (bn[30:23] == EXP_ONES) && (bn[22:0] == '0);
    b_nan       = (bn[30:23] == EXP_ONES) && (bn[22:0] != '0);
    special_in  = (a[30:23] == EXP_ONES) || (bn[30:23] == EXP_ONES);
    special_res = NAN_VAL;
    if (a_nan || b_nan)               special_res = NAN_VAL;
    else if (a_inf && b_inf)          special_res = (a[31] == bn[31]) ? {a[31], EXP_ONES, 23'h0} : NAN_VAL;
    else if (a_inf)                   special_res = {a[31], EXP_ONES, 23'h0};
    else if (b_inf)                   special_res = {bn[31], EXP_ONES, 23'h0};
  end

  // ALIGN: denormals become zero mantissas; the smaller operand is shifted right
  logic [23:0] x_man, y_man, man_l, man_s;
  logic [7:0]  exp_l, exp_s, diff;
  logic        x_ge, al_sign;
  logic [49:0] shifted;
  logic [EXT_W-1:0] al_small;

  always_comb begin
    x_man   = (x_q[30:23] == '0) ? '0 : {1'b1, x_q[22:0]};
    y_man   = (y_q[30:23] == '0) ? '0 : {1'b1, y_q[22:0]};
    x_ge    = {x_q[30:23], x_man} >= {y_q[30:23], y_man};
    man_l   = x_ge ? x_man : y_man;
    man_s   = x_ge ? y_man : x_man;
    exp_l   = x_ge ? x_q[30:23] : y_q[30:23];
    exp_s   = x_ge ? y_q[30:23] : x_q[30:23];
    al_sign = x_ge ? x_q[31] : y_q[31];
    diff    = exp_l - exp_s;
    shifted = {man_s, 26'b0} >> diff;
    if (diff >= 8'd26) al_small = {26'b0, |man_s};
    else               al_small = {shifted[49:24], |shifted[23:0]};
  end

  // NORM: carry-out shifts right; otherwise bring the leading one to bit 26
  logic [4:0]        lz, shamt;
  logic [SUM_W-1:0]  sum_sh;
  logic signed [9:0] nrm_exp;
  logic [EXT_W-1:0]  nrm_mant;

  lzc28 u_lzc (
    .din   (sum_q),
    .count (lz)
  );

  always_comb begin
    shamt    = lz - 5'd1;
    sum_sh   = sum_q << shamt;
    nrm_exp  = exp_q;
    nrm_mant = sum_sh[EXT_W-1:0];
    if (sum_q[27]) begin
      nrm_exp  = exp_q + 10'sd1;
      nrm_mant = {sum_q[27:2], |sum_q[1:0]};
    end else begin
      nrm_exp  = exp_q - $signed({5'b0, shamt});
    end
  end

  // ROUND: nearest-even on guard/round/sticky, then range checks
  logic              round_up;
  logic [24:0]       m25;
  logic signed [9:0] rnd_exp;
  logic [22:0]       rnd_mant;
  logic [WORD_W-1:0] rnd_res;

  always_comb begin
    round_up = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
    m25      = {1'b0, nm_q[26:3]} + {24'b0, round_up};
    rnd_exp  = exp_q + $signed({9'b0, m25[24]});
    rnd_mant = m25[24] ? m25[23:1] : m25[22:0];
    if (zero_q)                 rnd_res = '0;
    else if (rnd_exp >= 10'sd255) rnd_res = {sign_q, EXP_ONES, 23'h0};
    else if (rnd_exp <= 10'sd0)   rnd_res = {sign_q, 31'h0};
    else                        rnd_res = {sign_q, rnd_exp[7:0], rnd_mant};
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    s_d         = s_q;
    x_d         = x_q;
    y_d         = y_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mag_l_d     = mag_l_q;
    mag_s_d     = mag_s_q;
    sub_d       = sub_q;
    sum_d       = sum_q;
    nm_d        = nm_q;
    zero_d      = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d        = a;
          y_d        = bn;
          in_ready_d = 1'b0;
          if (special_in) begin
            s_d         = special_res;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d     = ALIGN;
          end
        end
      end
      ALIGN: begin
        sign_d  = al_sign;
        exp_d   = $signed({2'b00, exp_l});
        mag_l_d = {man_l, 3'b000};
        mag_s_d = al_small;
        sub_d   = x_q[31] ^ y_q[31];
        state_d = ADD;
      end
      ADD: begin
        sum_d   = sub_q ? ({1'b0, mag_l_q} - {1'b0, mag_s_q})
                        : ({1'b0, mag_l_q} + {1'b0, mag_s_q});
        state_d = NORM;
      end
      NORM: begin
        exp_d   = nrm_exp;
        nm_d    = nrm_mant;
        zero_d  = (sum_q == '0);
        state_d = ROUND;
      end
      ROUND: begin
        s_d         = rnd_res;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mag_l_q     <= '0;
      mag_s_q     <= '0;
      sub_q       <= 1'b0;
      sum_q       <= '0;
      nm_q        <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mag_l_q     <= mag_l_d;
      mag_s_q     <= mag_s_d;
      sub_q       <= sub_d;
      sum_q       <= sum_d;
      nm_q        <= nm_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;

endmodule

// File: tb/tb_ieee32float_subtractor.sv
// Vector-table and hand-sequenced bench for the binary32 subtractor, with an
// expected-result queue filled at accept and drained at output.
module tb_ieee32float_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    int          lat;
  } exp_t;

  vec_t vecs[17];
  exp_t sb[$];

  ieee32float_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one operand pair at a negedge; it is accepted at the next posedge.
  task automatic send(input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] vs, input int vlat);
    exp_t e;
    int   tries = 0;
    @(negedge clk);
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    check_int("in_ready_before_send", int'(in_ready), 1);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    e.s      = vs;
    e.lat    = vlat;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count negedges after accept until out_valid; 0 means the bound expired.
  task automatic wait_out(output int got);
    int n = 0;
    got = 0;
    while (got == 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) got = n;
    end
    if (got == 0) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got no out_valid expected within 20 cycles");
    end
  endtask

  task automatic run_one(input vec_t v, input int idx);
    int   got;
    exp_t e;
    out_ready = 1'b1;
    send(v.a, v.b, v.s, v.lat);
    wait_out(got);
    e = sb.pop_front();
    if (got != 0) begin
      check32($sformatf("vec%0d_s", idx), s, e.s);
      check_int($sformatf("vec%0d_latency", idx), got, e.lat);
    end
    @(negedge clk);
    check_int($sformatf("vec%0d_valid_drop", idx), int'(out_valid), 0);
  endtask

  initial begin
    int   got;
    int   seen;
    exp_t e;

    vecs[0]  = '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 5}; // 3 - 1
    vecs[1]  = '{32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF, 5}; // 1 - 2^-24
    vecs[2]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 5}; // exact zero
    vecs[3]  = '{32'h7F80_0000, 32'h7F80_0000, 32'hFFFF_FFFF, 1}; // inf - inf
    vecs[4]  = '{32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000, 1}; // inf - -inf
    vecs[5]  = '{32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 5}; // overflow
    vecs[6]  = '{32'h7FC0_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 1}; // NaN in
    vecs[7]  = '{32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 1}; // 1 - inf
    vecs[8]  = '{32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 5}; // 1 - 2
    vecs[9]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 5}; // 1 - -1 (carry)
    vecs[10] = '{32'h0000_0001, 32'h3F80_0000, 32'hBF80_0000, 5}; // denormal a
    vecs[11] = '{32'h0040_0000, 32'h0040_0000, 32'h0000_0000, 5}; // denormals
    vecs[12] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 5}; // -0 - +0
    vecs[13] = '{32'h3F80_0000, 32'hB380_0000, 32'h3F80_0000, 5}; // tie to even (down)
    vecs[14] = '{32'h3F80_0000, 32'hB440_0000, 32'h3F80_0002, 5}; // tie to even (up)
    vecs[15] = '{32'h0080_0000, 32'h0080_0001, 32'h8000_0000, 5}; // underflow flush
    vecs[16] = '{32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 5}; // sticky-only, round carry

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_int("reset_in_ready", int'(in_ready), 1);
    check_int("reset_out_valid", int'(out_valid), 0);
    check32("reset_s", s, 32'h0);

    for (int i = 0; i < 17; i++) run_one(vecs[i], i);

    // Back-pressure in DONE: result held, new operands ignored
    out_ready = 1'b0;
    send(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 5);
    wait_out(got);
    check_int("stall_latency", got, 5);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a        = 32'h3F80_0000;
      b        = 32'h3F80_0000;
      @(negedge clk);
      check_int("stall_out_valid", int'(out_valid), 1);
      check32("stall_s", s, 32'h4000_0000);
      check_int("stall_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    e = sb.pop_front();
    check32("stall_release_s", s, e.s);
    @(negedge clk);
    check_int("stall_after_valid", int'(out_valid), 0);
    check_int("stall_after_in_ready", int'(in_ready), 1);
    @(negedge clk);
    check_int("stall_no_ghost", int'(out_valid), 0);

    // Reset while the operation sits in ADD discards it entirely
    send(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 5);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check_int("midreset_out_valid", int'(out_valid), 0);
    check32("midreset_s", s, 32'h0);
    check_int("midreset_in_ready", int'(in_ready), 1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_int("midreset_no_result", seen, 0);

    // Recovery after reset
    run_one('{32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 5}, 99);
    check_int("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
